// File: rtl/alu_pipe_hs.sv
// alu_pipe_hs: 8-operation ALU with NZCV flags behind a 2-stage valid/ready
// pipeline (S1 = captured operands, S2 = registered result). Pipeline advance
// is throttled by a tick enable from a 3-bit divider (every 1/2/4/8 clocks).
// There are no derived clocks: every flop runs on i_clock.
//
// Ports:
//   i_clock, i_reset          clock, asynchronous active-high reset
//   i_enable                  0 freezes divider and pipeline advance
//   i_sel_rate[1:0]           advance rate: tick every 2**i_sel_rate clocks
//   i_valid / o_ready         operand handshake (o_ready is combinational)
//   i_op, i_data_a, i_data_b  operation code and operands
//   o_valid / i_ready         result handshake (o_valid registered)
//   o_data, o_flags           result and {N,Z,C,V}, registered
//   o_tick                    current advance strobe
module alu_pipe_hs #(
  parameter int N_BITS = 32,
  parameter int SH_W   = $clog2(N_BITS)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [1:0]        i_sel_rate,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_op,
  input  logic [N_BITS-1:0] i_data_a,
  input  logic [N_BITS-1:0] i_data_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [N_BITS-1:0] o_data,
  output logic [3:0]        o_flags,
  output logic              o_tick
);

  logic [2:0]        cnt_q, cnt_d;
  logic              s1_valid_q, s1_valid_d;
  logic [2:0]        op_q, op_d;
  logic [N_BITS-1:0] a_q, a_d, b_q, b_d;
  logic              s2_valid_q, s2_valid_d;
  logic [N_BITS-1:0] data_q, data_d;
  logic [3:0]        flags_q, flags_d;

  logic [2:0]        mask;
  logic              tick, out_free, accept, s2_load;

  // Divider: tick fires when the low i_sel_rate bits of cnt are all ones,
  // so a rate change applies from the very next comparison.
  always_comb begin
    mask = 3'b000;
    case (i_sel_rate)
      2'd0: mask = 3'b000;
      2'd1: mask = 3'b001;
      2'd2: mask = 3'b011;
      2'd3: mask = 3'b111;
      default: mask = 3'b000;
    endcase
  end

  assign tick     = i_enable & ((cnt_q & mask) == mask);
  assign out_free = ~s2_valid_q | i_ready;
  // Gate with reset so the producer sees no acceptance during reset.
  assign o_ready  = ~i_reset & tick & (~s1_valid_q | out_free);
  assign accept   = i_valid & o_ready;
  assign s2_load  = tick & out_free;

  assign o_tick   = tick;
  assign o_valid  = s2_valid_q;
  assign o_data   = data_q;
  assign o_flags  = flags_q;

  // ALU evaluated on the S1 operands.
  logic [N_BITS:0]   sum_ext, diff_ext;
  logic [SH_W-1:0]   sh_amt;
  logic [N_BITS-1:0] alu_res;
  logic              alu_c, alu_v;

  assign sum_ext  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_ext = {1'b0, a_q} - {1'b0, b_q};
  assign sh_amt   = b_q[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      3'b000: begin
        alu_res = sum_ext[N_BITS-1:0];
        alu_c   = sum_ext[N_BITS];
        alu_v   = (a_q[N_BITS-1] == b_q[N_BITS-1]) &&
                  (alu_res[N_BITS-1] != a_q[N_BITS-1]);
      end
      3'b001: begin
        alu_res = diff_ext[N_BITS-1:0];
        alu_c   = ~diff_ext[N_BITS];  // no borrow means a >= b
        alu_v   = (a_q[N_BITS-1] != b_q[N_BITS-1]) &&
                  (alu_res[N_BITS-1] != a_q[N_BITS-1]);
      end
      3'b010: alu_res = a_q & b_q;
      3'b011: alu_res = a_q | b_q;
      3'b100: alu_res = a_q ^ b_q;
      3'b101: alu_res = ~(a_q | b_q);
      3'b110: alu_res = a_q >> sh_amt;
      3'b111: alu_res = $signed(a_q) >>> sh_amt;
      default: alu_res = '0;
    endcase
  end

  // Next-state logic for divider and both pipeline stages.
  always_comb begin
    cnt_d      = i_enable ? cnt_q + 3'd1 : cnt_q;

    s1_valid_d = s1_valid_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      op_d       = i_op;
      a_d        = i_data_a;
      b_d        = i_data_b;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    data_d     = data_q;
    flags_d    = flags_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        data_d  = alu_res;
        flags_d = {alu_res[N_BITS-1], (alu_res == '0), alu_c, alu_v};
      end
    end else if (s2_valid_q & i_ready) begin
      // Consumer pops between ticks; the output handshake is never frozen.
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      s2_valid_q <= 1'b0;
      data_q     <= '0;
      flags_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s2_valid_q <= s2_valid_d;
      data_q     <= data_d;
      flags_q    <= flags_d;
    end
  end

endmodule

// File: doc/alu_pipe_hs.md
Name: alu_pipe_hs

Overview:
- Parametrised, handshaked successor to the team's registered 4-op ALU.
- 8 operations with NZCV flags and a 2-stage valid/ready pipeline (operand stage S1, result stage S2).
- Rate throttling uses a single-clock tick enable (divide by 1/2/4/8) instead of derived clocks; all flops run on i_clock.
- Sits between an operand producer and a result consumer in the datapath.

Parameters:
- N_BITS, 32: operand/result width; legal range >= 4, power of 2.
- SH_W, $clog2(N_BITS): shift-amount width (derived; do not override).

Ports:
- i_clock, in, 1: system clock, all state on rising edge.
- i_reset, in, 1: asynchronous, active-high reset.
- i_enable, in, 1: 0 freezes divider and pipeline advance; the output handshake stays live.
- i_sel_rate, in, 2: advance rate. 0 = every clock, 1 = every 2nd, 2 = every 4th, 3 = every 8th.
- i_valid, in, 1: operand beat valid.
- o_ready, out, 1: block accepts operand beat this cycle (combinational).
- i_op, in, 3: operation code, captured with operands.
- i_data_a, in, N_BITS: operand A.
- i_data_b, in, N_BITS: operand B.
- o_valid, out, 1: result valid (registered).
- i_ready, in, 1: consumer accepts result.
- o_data, out, N_BITS: result (registered).
- o_flags, out, 4: {N,Z,C,V} (registered).
- o_tick, out, 1: current advance strobe, for downstream throttling.

Behaviour:
Reset:
- cnt = 0, s1_valid = 0, s2_valid = 0, o_data = 0, o_flags = 0.
- o_valid = 0. o_ready = 0 while i_reset is high.

Divider:
- 3-bit cnt increments each clock when i_enable = 1, wraps 7 -> 0; it holds when i_enable = 0.
- mask = (1 << i_sel_rate) - 1.
- tick = i_enable & ((cnt & mask) == mask); o_tick = tick.
- A change of i_sel_rate takes effect the same cycle and loses no pipeline data.

Handshake:
- out_free = !s2_valid | i_ready.
- o_ready = tick & (!s1_valid | out_free).
- Accept = i_valid & o_ready: S1 captures a, b, op; s1_valid <= 1.
- S2 load = tick & out_free: s2_valid <= s1_valid; data and flags update only if s1_valid.
- Otherwise, if o_valid & i_ready, s2_valid <= 0.
- s1_valid clears on an S2 load that consumes S1 with no new accept the same cycle.
- Simultaneous accept, S1->S2 move and consumer pop in one cycle is legal: full throughput of 1 beat per tick.
- o_data/o_flags are stable while o_valid = 1 and i_ready = 0.
- Inputs are not sampled when o_ready = 0.

Latency and full/empty:
- Result is visible one tick after acceptance; at rate 0 that is 1 clock after the accept edge.
- With S2 stalled and S1 full, o_ready = 0 and nothing is lost or overwritten.

Operations, computed from S1:
- 000 ADD: C = carry-out; V = signed overflow.
- 001 SUB a-b: C = 1 when a >= b unsigned (no borrow); V = signed overflow.
- 010 AND, 011 OR, 100 XOR, 101 NOR: C = V = 0.
- 110 SRL, shift by b[SH_W-1:0]: C = V = 0.
- 111 SRA, arithmetic shift by b[SH_W-1:0]: C = V = 0.
- All ops: N = result[N_BITS-1]; Z = (result == 0).
- Result is truncated to N_BITS.

Reset mid-operation: all in-flight beats are discarded, and o_valid drops asynchronously.

Test Plan (N_BITS = 8):
- Rate 0, ADD a = 0x7F, b = 0x01, i_ready = 1 -> o_valid 1 clock after accept; o_data = 0x80; flags N = 1, Z = 0, C = 0, V = 1.
- SUB a = 0x05, b = 0x05 -> 0x00, Z = 1, C = 1, V = 0. Then SUB a = 0x03, b = 0x05 -> 0xFE, N = 1, C = 0. Then SRA a = 0x90, b = 0x0A (shift 2) -> 0xE4. Then NOR a = 0xF0, b = 0x0F -> 0x00, Z = 1.
- Backpressure: stream 4 beats with i_ready = 0 -> o_ready drops after 2 accepts and o_data holds the first result. Then release i_ready -> results appear in order, none dropped or duplicated.
- Rate 3, continuous i_valid and i_ready = 1 -> o_tick and o_ready pulse once per 8 clocks; one result per 8 clocks. Switching to rate 1 mid-stream -> a result every 2 clocks, with no lost beat.
- i_enable = 0 with S1 full and S2 free -> no S2 load and cnt holds; a pending o_valid result is still consumed when i_ready = 1.
- Assert i_reset while both stages are valid -> o_valid = 0 and o_ready = 0 immediately. After release, the first accept yields a fresh result with no stale data.
